// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C state encoding and bus-level constants
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WRITE,
        WR_ACK,
        READ,
        RD_ACK
    } i2c_state_e;

    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;
    localparam logic I2C_ACK      = 1'b0;
    localparam logic I2C_NACK     = 1'b1;

endpackage

// File: rtl/i2c_slave_if.sv
// rtl/i2c_slave_if.sv - byte-wide user handshake between the I2C target and its register block
interface i2c_slave_if;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_req;
    logic       busy;
    logic       stop_done;

    modport slave (
        input  tx_data,
        output rx_data,
        output rx_valid,
        output tx_req,
        output busy,
        output stop_done
    );

    modport master (
        output tx_data,
        input  rx_data,
        input  rx_valid,
        input  tx_req,
        input  busy,
        input  stop_done
    );
endinterface

// File: rtl/i2c_sync_edge.sv
// rtl/i2c_sync_edge.sv - scl/sda synchronizer with edge and START/STOP detection
module i2c_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl,
    input  logic sda,
    output logic scl_s,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_prev;
    logic                   sda_prev;

    // Flops reset to 1 (idle bus level) so leaving reset never fakes an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
            scl_prev <= scl_sync[SYNC_STAGES-1];
            sda_prev <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  =  scl_s & ~scl_prev;
    assign scl_fall  = ~scl_s &  scl_prev;
    assign start_det =  scl_s &  scl_prev & ~sda_s &  sda_prev;
    assign stop_det  =  scl_s &  scl_prev &  sda_s & ~sda_prev;

endmodule

// File: rtl/i2c_slave.sv
// rtl/i2c_slave.sv - 7-bit address I2C target with byte-wide rx/tx user interface
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scl,
    inout  wire         sda,
    i2c_slave_if.slave  user
);

    logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl       (scl),
        .sda       (sda),
        .scl_s     (scl_s),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    i2c_state_e  state;
    logic [3:0]  bit_cnt;
    logic [7:0]  shifter;
    logic        rw;
    logic        byte_full;
    logic        sda_low;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        tx_req;
    logic        busy;
    logic        stop_done;
    logic        sample_bit;

    assign sample_bit = scl_rise & scl_s;

    // Open-drain: only ever pull low; async reset clears sda_low immediately.
    assign sda = sda_low ? 1'b0 : 1'bz;

    assign user.rx_data   = rx_data;
    assign user.rx_valid  = rx_valid;
    assign user.tx_req    = tx_req;
    assign user.busy      = busy;
    assign user.stop_done = stop_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= 4'd0;
            shifter   <= 8'h00;
            rw        <= I2C_RW_WRITE;
            byte_full <= 1'b0;
            sda_low   <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            busy      <= 1'b0;
            stop_done <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            stop_done <= 1'b0;
            if (stop_det) begin
                state     <= IDLE;
                sda_low   <= 1'b0;
                stop_done <= busy;
                busy      <= 1'b0;
                bit_cnt   <= 4'd0;
                byte_full <= 1'b0;
            end else if (start_det) begin
                state     <= ADDR;
                sda_low   <= 1'b0;
                busy      <= 1'b0;
                bit_cnt   <= 4'd0;
                byte_full <= 1'b0;
            end else begin
                case (state)
                    IDLE: ;
                    ADDR, WRITE: begin
                        // byte_full marks that the next scl_fall ends the 8th bit.
                        if (sample_bit) begin
                            shifter <= {shifter[6:0], sda_s};
                            if (bit_cnt == 4'd7) begin
                                bit_cnt   <= 4'd0;
                                byte_full <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end else if (scl_fall && byte_full) begin
                            byte_full <= 1'b0;
                            if (state == WRITE) begin
                                rx_data  <= shifter;
                                rx_valid <= 1'b1;
                                sda_low  <= 1'b1;
                                state    <= WR_ACK;
                            end else if (shifter[7:1] == SLAVE_ADDR) begin
                                sda_low <= 1'b1;
                                busy    <= 1'b1;
                                rw      <= shifter[0];
                                state   <= ADDR_ACK;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (sample_bit && rw == I2C_RW_READ) begin
                            tx_req <= 1'b1;
                        end else if (scl_fall) begin
                            bit_cnt <= 4'd0;
                            if (rw == I2C_RW_WRITE) begin
                                sda_low <= 1'b0;
                                state   <= WRITE;
                            end else begin
                                shifter <= user.tx_data;
                                sda_low <= ~user.tx_data[7];
                                state   <= READ;
                            end
                        end
                    end
                    WR_ACK: begin
                        if (scl_fall) begin
                            sda_low <= 1'b0;
                            state   <= WRITE;
                        end
                    end
                    READ: begin
                        if (scl_fall) begin
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= 4'd0;
                                sda_low <= 1'b0;
                                state   <= RD_ACK;
                            end else begin
                                shifter <= {shifter[6:0], 1'b0};
                                sda_low <= ~shifter[6];
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    RD_ACK: begin
                        // byte_full here records that the master ACKed and wants another byte.
                        if (sample_bit) begin
                            if (sda_s == I2C_ACK) begin
                                tx_req    <= 1'b1;
                                byte_full <= 1'b1;
                            end else begin
                                busy  <= 1'b0;
                                state <= IDLE;
                            end
                        end else if (scl_fall && byte_full) begin
                            byte_full <= 1'b0;
                            shifter   <= user.tx_data;
                            sda_low   <= ~user.tx_data[7];
                            bit_cnt   <= 4'd0;
                            state     <= READ;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// tb/tb_i2c_slave.sv - bit-banged I2C master bench with transaction-level scoreboard
module tb_i2c_slave;

    localparam int Q = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic scl = 1'b1;
    logic m_sda_low = 1'b0;
    wire  sda;

    pullup (sda);
    assign sda = m_sda_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_slave_if u_if ();

    i2c_slave #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .scl   (scl),
        .sda   (sda),
        .user  (u_if)
    );

    int n_cmp = 0;
    int n_err = 0;
    int rx_cnt = 0, tx_cnt = 0, stop_cnt = 0;
    logic busy_seen = 1'b0;
    logic prev_rx = 1'b0, prev_stop = 1'b0;
    logic [7:0] exp_rx[$];
    logic [7:0] tx_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: written bytes must emerge in order, pulses are single-cycle and exclusive.
    always @(negedge clk) begin
        if (rst_n) begin
            if (u_if.busy) busy_seen = 1'b1;
            if (u_if.rx_valid) begin
                rx_cnt++;
                if (exp_rx.size() > 0) check("rx_data", u_if.rx_data, exp_rx.pop_front());
                else check("rx_unexpected", u_if.rx_valid, 0);
                check("rx_valid_width", prev_rx, 0);
            end
            if (u_if.tx_req) tx_cnt++;
            if (u_if.stop_done) begin
                stop_cnt++;
                check("stop_done_width", prev_stop, 0);
            end
            if (u_if.rx_valid || u_if.tx_req) check("rx_tx_excl", u_if.rx_valid & u_if.tx_req, 0);
            prev_rx   = u_if.rx_valid;
            prev_stop = u_if.stop_done;
        end
    end

    // Register block stand-in: supplies the next queued byte on each request.
    always @(negedge clk) begin
        if (rst_n && u_if.tx_req && tx_q.size() > 0) u_if.tx_data = tx_q.pop_front();
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clk_bit(input logic drive_low, output logic sampled);
        wait_clk(Q); m_sda_low = drive_low;
        wait_clk(Q); scl = 1'b1;
        wait_clk(Q); sampled = sda;
        wait_clk(Q); scl = 1'b0;
    endtask

    task automatic i2c_start();
        wait_clk(Q); m_sda_low = 1'b1;
        wait_clk(Q); scl = 1'b0;
    endtask

    task automatic i2c_rstart();
        wait_clk(Q); m_sda_low = 1'b0;
        wait_clk(Q); scl = 1'b1;
        wait_clk(Q); m_sda_low = 1'b1;
        wait_clk(Q); scl = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_clk(Q); m_sda_low = 1'b1;
        wait_clk(Q); scl = 1'b1;
        wait_clk(Q); m_sda_low = 1'b0;
        wait_clk(2 * Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(~b[i], s);
        clk_bit(1'b0, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b0, s);
            b[i] = s;
        end
        clk_bit(~nack, s);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        logic ack;
        logic [7:0] rd;
        logic [7:0] a0;
        int rx0, tx0, st0;
        u_if.tx_data = 8'h00;
        wait_clk(4);
        check("reset_sda", sda, 1);
        check("reset_rx_data", u_if.rx_data, 0);
        check("reset_rx_valid", u_if.rx_valid, 0);
        check("reset_tx_req", u_if.tx_req, 0);
        check("reset_busy", u_if.busy, 0);
        check("reset_stop_done", u_if.stop_done, 0);
        rst_n = 1'b1;
        wait_clk(4);

        // Write A5, 3C to 0x50
        rx0 = rx_cnt; st0 = stop_cnt;
        exp_rx.push_back(8'hA5); exp_rx.push_back(8'h3C);
        i2c_start();
        write_byte(8'hA0, ack); check("w_addr_ack", ack, 0);
        write_byte(8'hA5, ack); check("w_d0_ack", ack, 0);
        check("w_busy", u_if.busy, 1);
        write_byte(8'h3C, ack); check("w_d1_ack", ack, 0);
        i2c_stop();
        check("w_rx_count", rx_cnt - rx0, 2);
        check("w_stop_count", stop_cnt - st0, 1);
        check("w_busy_after", u_if.busy, 0);
        check("w_last_rx", u_if.rx_data, 8'h3C);

        // Wrong address 0x51
        rx0 = rx_cnt; st0 = stop_cnt; busy_seen = 1'b0;
        i2c_start();
        write_byte(8'hA2, ack); check("na_addr_nack", ack, 1);
        i2c_stop();
        check("na_busy_seen", busy_seen, 0);
        check("na_rx_count", rx_cnt - rx0, 0);
        check("na_stop_count", stop_cnt - st0, 0);

        // Read two bytes, ACK then NACK
        tx0 = tx_cnt; st0 = stop_cnt;
        tx_q.push_back(8'h96); tx_q.push_back(8'h0F);
        i2c_start();
        write_byte(8'hA1, ack); check("r_addr_ack", ack, 0);
        read_byte(1'b0, rd); check("r_byte0", rd, 8'h96);
        read_byte(1'b1, rd); check("r_byte1", rd, 8'h0F);
        wait_clk(2 * Q);
        check("r_sda_released", sda, 1);
        check("r_busy_after_nack", u_if.busy, 0);
        i2c_stop();
        check("r_tx_req_count", tx_cnt - tx0, 2);
        check("r_stop_count", stop_cnt - st0, 0);

        // Write 11 then repeated START into a read
        rx0 = rx_cnt; tx0 = tx_cnt;
        exp_rx.push_back(8'h11);
        tx_q.push_back(8'h77);
        i2c_start();
        write_byte(8'hA0, ack); check("sr_waddr_ack", ack, 0);
        write_byte(8'h11, ack); check("sr_wdata_ack", ack, 0);
        i2c_rstart();
        write_byte(8'hA1, ack); check("sr_raddr_ack", ack, 0);
        read_byte(1'b1, rd); check("sr_rbyte", rd, 8'h77);
        i2c_stop();
        check("sr_rx_count", rx_cnt - rx0, 1);
        check("sr_tx_count", tx_cnt - tx0, 1);

        // Reset while the address ACK is being driven
        a0 = 8'hA0;
        i2c_start();
        for (int i = 7; i >= 0; i--) clk_bit(~a0[i], ack);
        wait_clk(Q); m_sda_low = 1'b0;
        wait_clk(2);
        check("rst_ack_driven", sda, 0);
        rst_n = 1'b0;
        #1;
        check("rst_sda_released", sda, 1);
        check("rst_busy", u_if.busy, 0);
        check("rst_rx_data", u_if.rx_data, 0);
        check("rst_rx_valid", u_if.rx_valid, 0);
        check("rst_tx_req", u_if.tx_req, 0);
        check("rst_stop_done", u_if.stop_done, 0);
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(3);
        scl = 1'b1;
        wait_clk(2 * Q);
        rx0 = rx_cnt; st0 = stop_cnt;
        exp_rx.push_back(8'h5A);
        i2c_start();
        write_byte(8'hA0, ack); check("post_rst_addr_ack", ack, 0);
        write_byte(8'h5A, ack); check("post_rst_data_ack", ack, 0);
        i2c_stop();
        check("post_rst_rx_count", rx_cnt - rx0, 1);
        check("post_rst_stop_count", stop_cnt - st0, 1);

        // Zero-byte write
        rx0 = rx_cnt; st0 = stop_cnt;
        i2c_start();
        write_byte(8'hA0, ack); check("zb_addr_ack", ack, 0);
        i2c_stop();
        check("zb_rx_count", rx_cnt - rx0, 0);
        check("zb_stop_count", stop_cnt - st0, 1);
        check("zb_busy", u_if.busy, 0);

        check("exp_rx_drained", exp_rx.size(), 0);
        check("tx_q_drained", tx_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
